// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seg7_pkg                                                     |
// | Description : Shared 7-segment definitions. Holds the segment pattern      |
// |               type, the ten digit patterns (active-high, {a,b,c,d,e,f,g}, |
// |               MSB = a), the invalid-BCD code and the pattern->BCD lookup   |
// |               that the encoder side uses as well.                          |
// |               Optional feature macro: SEG_DP_EN (adds a decimal-point bit  |
// |               as the LSB of the segment bus).                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_D0 = 7'b1111110;
    localparam seg7_t SEG7_D1 = 7'b0110000;
    localparam seg7_t SEG7_D2 = 7'b1101101;
    localparam seg7_t SEG7_D3 = 7'b1111001;
    localparam seg7_t SEG7_D4 = 7'b0110011;
    localparam seg7_t SEG7_D5 = 7'b1011011;
    localparam seg7_t SEG7_D6 = 7'b0011111;
    localparam seg7_t SEG7_D7 = 7'b1110000;
    localparam seg7_t SEG7_D8 = 7'b1111111;
    localparam seg7_t SEG7_D9 = 7'b1110011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Width of the physical segment bus: the decimal point rides in the LSB.
`ifdef SEG_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    // Returns {err, bcd}. Anything outside the ten digit shapes (blank
    // included) maps to err=1, bcd=BCD_INVALID.
    function automatic logic [4:0] seg7_to_bcd(input seg7_t seg);
        logic [4:0] w_res;
        case (seg)
            SEG7_D0: w_res = {1'b0, 4'd0};
            SEG7_D1: w_res = {1'b0, 4'd1};
            SEG7_D2: w_res = {1'b0, 4'd2};
            SEG7_D3: w_res = {1'b0, 4'd3};
            SEG7_D4: w_res = {1'b0, 4'd4};
            SEG7_D5: w_res = {1'b0, 4'd5};
            SEG7_D6: w_res = {1'b0, 4'd6};
            SEG7_D7: w_res = {1'b0, 4'd7};
            SEG7_D8: w_res = {1'b0, 4'd8};
            SEG7_D9: w_res = {1'b0, 4'd9};
            default: w_res = {1'b1, BCD_INVALID};
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : seg7_scan_decoder_if                                         |
// | Description : Display-bus monitor inputs and frame hand-off outputs of the |
// |               scan decoder.                                                |
// |   seg_in     segment lines {a..g} (plus dp as LSB with SEG_DP_EN)          |
// |   digit_sel  one-hot digit enable, bit i = digit i                         |
// |   out_ready  consumer ready                                                |
// |   out_valid  frame available, held until accepted                          |
// |   bcd_out    digit i in bits [4i+3:4i]                                     |
// |   digit_err  per-digit unknown-pattern flag                                |
// |   overrun    sticky frame-dropped flag                                     |
// |   dp_out     per-digit decimal point (SEG_DP_EN only)                      |
// |               Modports: slave = decoder, master = bus driver/consumer.     |
// |               Optional feature macro: SEG_DP_EN.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seg7_scan_decoder_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [SEG_W-1:0]        seg_in;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    out_ready;
    logic                    out_valid;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    overrun;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   dp_out;

    modport slave (
        input  seg_in, digit_sel, out_ready,
        output out_valid, bcd_out, digit_err, overrun, dp_out
    );
    modport master (
        output seg_in, digit_sel, out_ready,
        input  out_valid, bcd_out, digit_err, overrun, dp_out
    );
`else
    modport slave (
        input  seg_in, digit_sel, out_ready,
        output out_valid, bcd_out, digit_err, overrun
    );
    modport master (
        output seg_in, digit_sel, out_ready,
        input  out_valid, bcd_out, digit_err, overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder_pattern_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_pattern_decoder                                         |
// | Description : Combinational 7-segment pattern -> BCD lookup.               |
// |   seg  in  7  segment pattern {a..g}, active-high                          |
// |   bcd  out 4  decoded digit, BCD_INVALID for unknown shapes                |
// |   err  out 1  pattern is not one of the ten digit shapes                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  wire seg7_t      seg,
    output logic [3:0]      bcd,
    output logic            err
);
    logic [4:0] w_dec;

    assign w_dec = seg7_to_bcd(seg);
    assign err   = w_dec[4];
    assign bcd   = w_dec[3:0];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_scan_decoder                                            |
// | Description : Watches a multiplexed 7-segment display bus, decodes each    |
// |               digit once it has dwelt STABLE_CYCLES samples, assembles a   |
// |               NUM_DIGITS frame and hands it off with valid/ready.          |
// |   clk    in   system clock, rising edge                                   |
// |   reset  in   synchronous, active-high                                     |
// |   bus    slave modport of seg7_scan_decoder_if (segments, digit select,    |
// |          out_ready / out_valid, bcd_out, digit_err, overrun[, dp_out])     |
// |               Optional feature macro: SEG_DP_EN (decimal point capture).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seg7_scan_decoder_if.slave bus
);
    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // Sample stage and dwell tracking
    logic [SEG_W-1:0]        r_seg_smp;
    logic [NUM_DIGITS-1:0]   r_sel_smp;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_change;
    logic                    w_sel_onehot;
    logic                    w_fire;

    // Decoder on the value entering the sample register
    seg7_t                   w_pattern;
    logic [3:0]              w_dec_bcd;
    logic                    w_dec_err;

    // Frame assembly
    logic [4*NUM_DIGITS-1:0] r_slot_bcd;
    logic [NUM_DIGITS-1:0]   r_slot_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_drop;

    // Output stage
    logic [4*NUM_DIGITS-1:0] r_bcd_out;
    logic [NUM_DIGITS-1:0]   r_err_out;
    logic                    r_valid;
    logic                    r_overrun;

`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   r_slot_dp;
    logic [NUM_DIGITS-1:0]   r_dp_out;
`endif

    assign w_pattern = bus.seg_in[SEG_W-1 -: 7];

    seg7_pattern_decoder u_pattern_decoder (
        .seg (w_pattern),
        .bcd (w_dec_bcd),
        .err (w_dec_err)
    );

    // The incoming sample is compared with the one already held, so the
    // counter reaches STABLE_CYCLES on the edge that takes the
    // STABLE_CYCLES-th identical sample and the slot is written right there.
    assign w_change     = (bus.seg_in != r_seg_smp) || (bus.digit_sel != r_sel_smp);
    assign w_sel_onehot = $onehot(bus.digit_sel);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_sel_onehot) begin
            w_cnt_next = '0;
        end else if (w_change) begin
            w_cnt_next = C_CNT_ONE;
        end else if (r_cnt != C_CNT_FULL) begin
            w_cnt_next = r_cnt + C_CNT_ONE;
        end
    end

    // Fire only on the transition into the full count: a saturated counter
    // with unchanged input means this dwell was already captured.
    assign w_fire = w_sel_onehot && (w_cnt_next == C_CNT_FULL) &&
                    (w_change || (r_cnt != C_CNT_FULL));

    assign w_full   = &r_mask;
    assign w_accept = r_valid & bus.out_ready;
    assign w_load   = w_full & (~r_valid | bus.out_ready);
    assign w_drop   = w_full & r_valid & ~bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_smp <= '0;
            r_sel_smp <= '0;
            r_cnt     <= '0;
        end else begin
            r_seg_smp <= bus.seg_in;
            r_sel_smp <= bus.digit_sel;
            r_cnt     <= w_cnt_next;
        end
    end

    // A completed frame leaves the mask on the next edge whether it was
    // loaded or dropped; a capture on that same edge starts the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_slot_bcd <= '0;
            r_slot_err <= '0;
`ifdef SEG_DP_EN
            r_slot_dp  <= '0;
`endif
        end else begin
            r_mask <= (w_full ? '0 : r_mask) | (w_fire ? bus.digit_sel : '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_fire && bus.digit_sel[i]) begin
                    r_slot_bcd[4*i +: 4] <= w_dec_bcd;
                    r_slot_err[i]        <= w_dec_err;
`ifdef SEG_DP_EN
                    r_slot_dp[i]         <= bus.seg_in[0];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd_out <= '0;
            r_err_out <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef SEG_DP_EN
            r_dp_out  <= '0;
`endif
        end else begin
            if (w_load) begin
                r_bcd_out <= r_slot_bcd;
                r_err_out <= r_slot_err;
                r_valid   <= 1'b1;
`ifdef SEG_DP_EN
                r_dp_out  <= r_slot_dp;
`endif
            end else if (w_accept) begin
                r_valid   <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.digit_err = r_err_out;
    assign bus.overrun   = r_overrun;
`ifdef SEG_DP_EN
    assign bus.dp_out    = r_dp_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_scan_decoder                                         |
// | Description : Directed self-checking bench for seg7_scan_decoder with      |
// |               NUM_DIGITS=4, STABLE_CYCLES=4. Accepted frames are logged   |
// |               by a monitor and compared with hand-computed values.         |
// |               Optional feature macro: SEG_DP_EN (adds decimal-point case). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 4;

    localparam logic [6:0] P0      = 7'b1111110;
    localparam logic [6:0] P1      = 7'b0110000;
    localparam logic [6:0] P2      = 7'b1101101;
    localparam logic [6:0] P3      = 7'b1111001;
    localparam logic [6:0] P4      = 7'b0110011;
    localparam logic [6:0] P5      = 7'b1011011;
    localparam logic [6:0] P6      = 7'b0011111;
    localparam logic [6:0] P7      = 7'b1110000;
    localparam logic [6:0] P8      = 7'b1111111;
    localparam logic [6:0] P9      = 7'b1110011;
    localparam logic [6:0] P_BLANK = 7'b0000000;
    localparam logic [6:0] P_BAD   = 7'b1000001;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [23:0] acc_q[$];   // {dp, err, bcd} of each accepted frame
`ifdef SEG_DP_EN
    logic cur_dp = 1'b0;
`endif

    seg7_scan_decoder_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
`ifdef SEG_DP_EN
            acc_q.push_back({bus.dp_out, bus.digit_err, bus.bcd_out});
`else
            acc_q.push_back({4'h0, bus.digit_err, bus.bcd_out});
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (acc_q.size() != 0) obs = 32'(acc_q.pop_front());
        check(tag, obs, 32'(exp));
    endtask

    // Drive one digit (idx<0 deselects all) and hold it for a number of cycles.
    task automatic show(input int idx, input logic [6:0] pat, input int cycles);
        bus.digit_sel = (idx < 0) ? 4'b0000 : 4'(1 << idx);
`ifdef SEG_DP_EN
        bus.seg_in = {pat, cur_dp};
`else
        bus.seg_in = pat;
`endif
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 6);
        show(1, p1, 6);
        show(2, p2, 6);
        show(3, p3, 6);
        show(-1, P_BLANK, 3);
    endtask

    initial begin
        reset         = 1'b1;
        bus.seg_in    = '0;
        bus.digit_sel = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid",   32'(bus.out_valid), 32'd0);
        check("rst_bcd",     32'(bus.bcd_out),   32'h0);
        check("rst_err",     32'(bus.digit_err), 32'h0);
        check("rst_overrun", 32'(bus.overrun),   32'd0);
`ifdef SEG_DP_EN
        check("rst_dp",      32'(bus.dp_out),    32'h0);
`endif
        @(posedge clk);
        #1;

        // Basic frame 3,1,4,1
        bus.out_ready = 1'b1;
        scan4(P3, P1, P4, P1);
        check("t1_count", 32'(acc_q.size()), 32'd1);
        check_frame("t1_frame", {4'h0, 4'h0, 16'h1413});
        check("t1_valid_drop", 32'(bus.out_valid), 32'd0);

        // Short dwell on digit 2 does not capture
        show(0, P5, 6);
        show(1, P6, 6);
        show(2, P7, STABLE_CYCLES - 1);
        show(3, P8, 6);
        show(-1, P_BLANK, 3);
        check("t2_no_frame", 32'(acc_q.size()), 32'd0);
        show(2, P7, 6);
        show(-1, P_BLANK, 3);
        check("t2_count", 32'(acc_q.size()), 32'd1);
        check_frame("t2_frame", {4'h0, 4'h0, 16'h8765});

        // Unknown patterns
        scan4(P_BLANK, P_BAD, P9, P2);
        check_frame("t3_frame", {4'h0, 4'b0011, 16'h29FF});

        // Back-pressure, latency and overrun
        bus.out_ready = 1'b0;
        show(0, P0, 6);
        show(1, P1, 6);
        show(2, P2, 6);
        show(3, P3, 0);
        repeat (STABLE_CYCLES) @(posedge clk);
        @(negedge clk);
        check("t4_lat_pre", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_lat_post", 32'(bus.out_valid), 32'd1);
        check("t4_bcd_a",    32'(bus.bcd_out),   32'h3210);
        @(posedge clk);
        #1;
        scan4(P4, P5, P6, P7);
        check("t4_held_valid", 32'(bus.out_valid), 32'd1);
        check("t4_held_bcd",   32'(bus.bcd_out),   32'h3210);
        check("t4_overrun",    32'(bus.overrun),   32'd1);
        check("t4_none_acc",   32'(acc_q.size()),  32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("t4_valid_clr",   32'(bus.out_valid), 32'd0);
        check("t4_overrun_clr", 32'(bus.overrun),   32'd0);
        check_frame("t4_frame", {4'h0, 4'h0, 16'h3210});
        @(posedge clk);
        #1;

        // Multi-hot select and reset mid-frame
        bus.out_ready = 1'b1;
        show(2, P9, 6);
        show(3, P8, 6);
        bus.digit_sel = 4'b0011;
`ifdef SEG_DP_EN
        bus.seg_in = {P8, 1'b0};
`else
        bus.seg_in = P8;
`endif
        repeat (10) @(posedge clk);
        #1;
        show(-1, P_BLANK, 3);
        check("t5_multihot", 32'(acc_q.size()), 32'd0);
        show(0, P5, 6);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        show(1, P4, 6);
        show(-1, P_BLANK, 3);
        check("t5_after_rst",   32'(acc_q.size()),  32'd0);
        check("t5_valid_low",   32'(bus.out_valid), 32'd0);
        show(0, P3, 6);
        show(2, P2, 6);
        show(3, P1, 6);
        show(-1, P_BLANK, 3);
        check_frame("t5_frame", {4'h0, 4'h0, 16'h1243});

        // Accept and load on the same edge; last capture of a digit wins
        bus.out_ready = 1'b0;
        scan4(P1, P2, P3, P4);
        check("t6_valid_a", 32'(bus.out_valid), 32'd1);
        check("t6_bcd_a",   32'(bus.bcd_out),   32'h4321);
        show(0, P0, 6);
        show(0, P9, 6);
        show(1, P8, 6);
        show(2, P7, 6);
        show(3, P6, 0);
        repeat (STABLE_CYCLES) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t6_old_held", 32'(bus.bcd_out), 32'h4321);
        @(posedge clk);
        @(negedge clk);
        check("t6_valid_stays", 32'(bus.out_valid), 32'd1);
        check("t6_bcd_b",       32'(bus.bcd_out),   32'h6789);
        check("t6_overrun",     32'(bus.overrun),   32'd0);
        @(posedge clk);
        #1;
        show(-1, P_BLANK, 3);
        check_frame("t6_frame_a", {4'h0, 4'h0, 16'h4321});
        check_frame("t6_frame_b", {4'h0, 4'h0, 16'h6789});
        check("t6_drained", 32'(bus.out_valid), 32'd0);

`ifdef SEG_DP_EN
        // Decimal point capture; all-ones decodes as 8 with dp set
        cur_dp = 1'b1;
        show(0, P8, 6);
        cur_dp = 1'b0;
        show(1, P1, 6);
        cur_dp = 1'b1;
        show(2, P2, 6);
        cur_dp = 1'b0;
        show(3, P3, 6);
        show(-1, P_BLANK, 3);
        check_frame("t7_dp_frame", {4'b0101, 4'h0, 16'h3218});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
